// File: rtl/stdp_controller.sv
// STDP sequencer: timestamps pre/post spikes and applies halving-decay LTP/LTD
// steps to a saturating synaptic weight through an IDLE/CALC/APPLY FSM.
module stdp_controller #(
  parameter int W_WIDTH = 8,
  parameter int T_WIDTH = 4,
  parameter int WINDOW  = 8,
  parameter int A_PLUS  = 16,
  parameter int A_MINUS = 16,
  parameter int W_INIT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
  input  logic               weight_load,
  input  logic [W_WIDTH-1:0] weight_in,
  output logic [W_WIDTH-1:0] weight,
  output logic               busy,
  output logic               update_done,
  output logic               update_dir,
  output logic [7:0]         drop_cnt
);

  localparam logic [T_WIDTH-1:0] WIN  = T_WIDTH'(WINDOW);
  localparam logic [W_WIDTH-1:0] AMPP = W_WIDTH'(A_PLUS);
  localparam logic [W_WIDTH-1:0] AMPM = W_WIDTH'(A_MINUS);

  typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;
  state_t state;

  logic [T_WIDTH-1:0] pre_cnt, post_cnt, dt;
  logic               pre_vld, post_vld, dir;
  logic               ev_ltp, ev_ltd, event_hit;
  logic [W_WIDTH-1:0] result, amp, delta, sat;
  logic [W_WIDTH:0]   sum, diff;

  // Counters restart at 1 on their own spike, so the registered value seen at
  // the partner spike is exactly the edge distance between the two.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pre_vld <= 1'b0;
    end else if (pre_spike) begin
      pre_cnt <= T_WIDTH'(1);
      pre_vld <= 1'b1;
    end else if (pre_vld) begin
      if (pre_cnt >= WIN) pre_vld <= 1'b0;
      else                pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_cnt <= '0;
      post_vld <= 1'b0;
    end else if (post_spike) begin
      post_cnt <= T_WIDTH'(1);
      post_vld <= 1'b1;
    end else if (post_vld) begin
      if (post_cnt >= WIN) post_vld <= 1'b0;
      else                 post_cnt <= post_cnt + 1'b1;
    end
  end

  assign ev_ltp    = learn_en & post_spike & ~pre_spike & pre_vld;
  assign ev_ltd    = learn_en & pre_spike & ~post_spike & post_vld;
  assign event_hit = ev_ltp | ev_ltd;

  always_comb begin
    amp   = dir ? AMPP : AMPM;
    delta = amp >> (dt - 1'b1);
    sum   = {1'b0, weight} + {1'b0, delta};
    diff  = {1'b0, weight} - {1'b0, delta};
    if (dir) sat = sum[W_WIDTH]  ? '1 : sum[W_WIDTH-1:0];
    else     sat = diff[W_WIDTH] ? '0 : diff[W_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      weight      <= W_WIDTH'(W_INIT);
      busy        <= 1'b0;
      update_done <= 1'b0;
      update_dir  <= 1'b0;
      drop_cnt    <= '0;
      dt          <= '0;
      dir         <= 1'b0;
      result      <= '0;
    end else begin
      update_done <= 1'b0;
      if (weight_load) begin
        weight <= weight_in;
        state  <= IDLE;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (event_hit) begin
            dt    <= ev_ltp ? pre_cnt : post_cnt;
            dir   <= ev_ltp;
            state <= CALC;
            busy  <= 1'b1;
          end
          CALC: begin
            result <= sat;
            state  <= APPLY;
            busy   <= 1'b1;
            if (event_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
          end
          APPLY: begin
            weight      <= result;
            update_done <= 1'b1;
            update_dir  <= dir;
            // back-to-back: an event on the write edge is accepted directly
            if (event_hit) begin
              dt    <= ev_ltp ? pre_cnt : post_cnt;
              dir   <= ev_ltp;
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/stdp_controller.md
Name: stdp_controller

Overview:
- Sequences spike-timing-dependent plasticity for the two-neuron LIF pair.
- Timestamps presynaptic and postsynaptic spikes, detects causal (pre→post) and anti-causal (post→pre) pairs inside a timing window, and runs a small FSM that applies a halving-decay potentiation or depression step to a saturating synaptic weight register.
- Sits between the spike outputs of the two lif instances and the synaptic-weight consumer in the top level.

Parameters:
- W_WIDTH, 8: weight width, unsigned.
- T_WIDTH, 4: spike-interval counter width.
- WINDOW, 8: max pairing interval in cycles; must be less than 2^T_WIDTH - 1.
- A_PLUS, 16: LTP amplitude at dt=1.
- A_MINUS, 16: LTD amplitude at dt=1.
- W_INIT, 16: weight value after reset.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- pre_spike, input, 1: presynaptic spike, one-cycle pulse.
- post_spike, input, 1: postsynaptic spike, one-cycle pulse.
- learn_en, input, 1: 1 = pairing events may start updates.
- weight_load, input, 1: load weight_in into the weight register.
- weight_in, input, W_WIDTH: value for weight_load.
- weight, output, W_WIDTH: current synaptic weight.
- busy, output, 1: FSM is not in IDLE.
- update_done, output, 1: one-cycle pulse when weight is written by an update.
- update_dir, output, 1: direction of the last update; 1 = LTP, 0 = LTD; valid with update_done.
- drop_cnt, output, 8: saturating count of pairing events dropped while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - weight = W_INIT.
  - busy = 0, update_done = 0, update_dir = 0, drop_cnt = 0.
  - Both interval counters invalid; state = IDLE.
  - Reset asserted mid-update aborts the update; no update_done is issued.
- Interval counters (pre_cnt/pre_vld and post_cnt/post_vld; pre shown, post identical):
  - On a pre_spike edge: pre_cnt <= 1, pre_vld <= 1.
  - Else, if pre_vld: pre_cnt increments.
  - When pre_cnt would exceed WINDOW, pre_vld <= 0.
  - Counters run regardless of learn_en and FSM state.
- Pairing events, evaluated on the sampled edge using registered counter values:
  - LTP event: post_spike=1, pre_spike=0, pre_vld=1. dt = pre_cnt.
  - LTD event: pre_spike=1, post_spike=0, post_vld=1. dt = post_cnt.
  - dt therefore equals the edge distance between the two spikes, 1..WINDOW.
  - Simultaneous pre_spike and post_spike: no event. Both counters restart at 1.
  - learn_en=0: events are ignored and not counted as drops.
- FSM states: IDLE, CALC, APPLY.
- IDLE:
  - On an event: latch dt and direction, go to CALC.
- CALC:
  - delta = A_PLUS >> (dt-1) for LTP, A_MINUS >> (dt-1) for LTD.
  - Compute the saturated result, W_WIDTH+1-bit intermediate:
    - LTP: min(weight + delta, 2^W_WIDTH - 1).
    - LTD: max(weight - delta, 0).
  - Register the result, go to APPLY.
- APPLY:
  - Write weight; pulse update_done; set update_dir; go to IDLE.
- Latency:
  - Event sampled at edge E → new weight and update_done visible after edge E+2.
  - busy is high after edges E and E+1.
  - A new event can be accepted at edge E+2.
- delta = 0 (large dt): the update still completes and pulses update_done; weight is unchanged.
- Events arriving while busy are dropped. drop_cnt increments and saturates at 255.
- weight_load:
  - Highest priority after rst.
  - weight <= weight_in at the next edge.
  - Aborts any in-flight update: state <= IDLE, no update_done.
  - An event on the same edge is discarded and not counted.

Test Plan:
- Causal pair, dt=1: rst, weight=16, learn_en=1; pre at edge 10, post at edge 11 → weight=32 and update_done=1, update_dir=1 after edge 13.
- Anti-causal pair, dt=2: weight=16; post at edge 10, pre at edge 12 → weight=8 and update_dir=0 after edge 14.
- Window and delta:
  - Pre→post with dt=8 → delta=0, update_done pulses, weight stays 16.
  - dt=9 → no update_done.
- Saturation:
  - weight_load 250, causal dt=1 → 255.
  - weight_load 3, anti-causal dt=1 → 0.
- Coincidence and busy:
  - Pre and post on the same edge → no update.
  - Two LTP events one edge apart → the second is dropped; drop_cnt=1; weight reflects one update only.
- Abort:
  - weight_load=1 with weight_in=100 one edge after an event → weight=100, no update_done.
  - rst during CALC → weight=W_INIT, busy=0.
